// File: rtl/dec_pipe.sv
// dec_pipe: pipelined N-to-2^N write-enable decoder with stall, flush and
// optional suppression of the hardwired zero register.
module dec_pipe #(
    parameter int unsigned N         = 5,
    parameter int unsigned STAGES    = 2,
    parameter bit          MASK_ZERO = 1'b1,
    parameter int unsigned ZERO_IDX  = (1 << N) - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        addr_in,
    input  logic                en_in,
    input  logic                stall,
    input  logic                flush,
    output logic [(1<<N)-1:0]   out,
    output logic [N-1:0]        addr_out,
    output logic                en_out
);

    localparam int unsigned WIDTH = 1 << N;

    // Bits allowed to assert; the zero register bit is cleared when masking.
    localparam logic [WIDTH-1:0] KEEP_MASK =
        MASK_ZERO ? ~(WIDTH'(1) << ZERO_IDX) : {WIDTH{1'b1}};

    // Pipeline entries; index STAGES-1 is the last stage.
    logic [N-1:0] addr_q [STAGES];
    logic         en_q   [STAGES];

    // Decoded vector kept in step with the last stage so out is a flop.
    logic [WIDTH-1:0] out_q;

    // Value that will enter the last stage on the next advancing edge.
    logic [N-1:0]     feed_addr;
    logic             feed_en;
    logic [WIDTH-1:0] feed_vec;

    // Select the source feeding the last stage.
    generate
        if (STAGES == 1) begin : g_feed_in
            assign feed_addr = addr_in;
            assign feed_en   = en_in;
        end else begin : g_feed_pipe
            assign feed_addr = addr_q[STAGES-2];
            assign feed_en   = en_q[STAGES-2];
        end
    endgenerate

    // Decode the incoming last-stage entry one edge early.
    always_comb begin
        feed_vec = '0;
        feed_vec = (WIDTH'(feed_en) << feed_addr) & KEEP_MASK;
    end

    // Pipeline advance: reset and flush clear, stall holds, otherwise shift.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                addr_q[k] <= '0;
                en_q[k]   <= 1'b0;
            end
            out_q <= '0;
        end else if (!stall) begin
            addr_q[0] <= addr_in;
            en_q[0]   <= en_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                addr_q[k] <= addr_q[k-1];
                en_q[k]   <= en_q[k-1];
            end
            out_q <= feed_vec;
        end
    end

    assign out      = out_q;
    assign addr_out = addr_q[STAGES-1];
    assign en_out   = en_q[STAGES-1];

endmodule

// File: tb/tb_dec_pipe.sv
// tb_dec_pipe: randomized scoreboard bench for dec_pipe across three
// configurations sharing one stimulus stream.
module tb_dec_pipe;

    typedef struct packed {
        logic [31:0] out;
        logic [4:0]  addr;
        logic        en;
    } exp_t;

    typedef struct packed {
        logic [4:0] addr;
        logic       en;
    } req_t;

    logic        clk;
    logic        reset;
    logic [4:0]  addr_in;
    logic        en_in;
    logic        stall;
    logic        flush;

    logic [31:0] out_a, out_b, out_c;
    logic [4:0]  addr_a, addr_b, addr_c;
    logic        en_a, en_b, en_c;

    int checks   = 0;
    int failures = 0;

    // Accepted requests since the last clear, one list per configuration.
    req_t hist_a[$];
    req_t hist_b[$];
    req_t hist_c[$];

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];

    // A: defaults (STAGES=2, masked)
    dec_pipe #(.N(5), .STAGES(2), .MASK_ZERO(1'b1), .ZERO_IDX(31)) dut_a (
        .clk(clk), .reset(reset), .addr_in(addr_in), .en_in(en_in),
        .stall(stall), .flush(flush),
        .out(out_a), .addr_out(addr_a), .en_out(en_a)
    );

    // B: no zero masking
    dec_pipe #(.N(5), .STAGES(2), .MASK_ZERO(1'b0), .ZERO_IDX(31)) dut_b (
        .clk(clk), .reset(reset), .addr_in(addr_in), .en_in(en_in),
        .stall(stall), .flush(flush),
        .out(out_b), .addr_out(addr_b), .en_out(en_b)
    );

    // C: four-deep pipeline
    dec_pipe #(.N(5), .STAGES(4), .MASK_ZERO(1'b1), .ZERO_IDX(31)) dut_c (
        .clk(clk), .reset(reset), .addr_in(addr_in), .en_in(en_in),
        .stall(stall), .flush(flush),
        .out(out_c), .addr_out(addr_c), .en_out(en_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last stage holds the request accepted `stages` advancing edges ago.
    function automatic exp_t predict(input req_t h[$], input int stages, input bit mask);
        exp_t e;
        req_t r;
        r = '0;
        if (h.size() >= stages) r = h[h.size() - stages];
        e.en   = r.en;
        e.addr = r.addr;
        e.out  = 32'd0;
        if (r.en && !(mask && r.addr == 5'd31)) e.out = 32'd1 << r.addr;
        return e;
    endfunction

    task automatic keep_recent(inout req_t h[$], input int stages);
        while (h.size() > stages) void'(h.pop_front());
    endtask

    // Apply the edge's effect to the model and queue expected outputs.
    task automatic model_step();
        req_t r;
        r.addr = addr_in;
        r.en   = en_in;
        if (reset || flush) begin
            hist_a.delete();
            hist_b.delete();
            hist_c.delete();
        end else if (!stall) begin
            hist_a.push_back(r);
            hist_b.push_back(r);
            hist_c.push_back(r);
            keep_recent(hist_a, 2);
            keep_recent(hist_b, 2);
            keep_recent(hist_c, 4);
        end
        sb_a.push_back(predict(hist_a, 2, 1'b1));
        sb_b.push_back(predict(hist_b, 2, 1'b0));
        sb_c.push_back(predict(hist_c, 4, 1'b1));
    endtask

    // One clock cycle with the given inputs.
    task automatic cyc(input logic r, input logic f, input logic s,
                       input logic e, input logic [4:0] a);
        reset   = r;
        flush   = f;
        stall   = s;
        en_in   = e;
        addr_in = a;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output sample is compared with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                check("a_out", out_a, e.out);
                check("a_addr", 32'(addr_a), 32'(e.addr));
                check("a_en", 32'(en_a), 32'(e.en));
            end
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                check("b_out", out_b, e.out);
                check("b_addr", 32'(addr_b), 32'(e.addr));
                check("b_en", 32'(en_b), 32'(e.en));
            end
            if (sb_c.size() > 0) begin
                e = sb_c.pop_front();
                check("c_out", out_c, e.out);
                check("c_addr", 32'(addr_c), 32'(e.addr));
                check("c_en", 32'(en_c), 32'(e.en));
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        stall   = 1'b0;
        en_in   = 1'b0;
        addr_in = 5'd0;

        // Reset then idle
        cyc(1, 0, 0, 0, 5'd0);
        cyc(1, 0, 0, 0, 5'd0);
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Basic decode
        cyc(0, 0, 0, 1, 5'd5);
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Streaming
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 5'(i));
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Zero register, masked and unmasked
        cyc(0, 0, 0, 1, 5'd31);
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Stall holding two requests
        cyc(0, 0, 0, 1, 5'd7);
        cyc(0, 0, 0, 1, 5'd9);
        repeat (3) cyc(0, 0, 1, 1, 5'd12);
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Flush and stall together with requests in flight
        cyc(0, 0, 0, 1, 5'd3);
        cyc(0, 0, 0, 1, 5'd4);
        cyc(0, 1, 1, 1, 5'd6);
        repeat (4) cyc(0, 0, 0, 0, 5'd0);

        // Reset mid-stream
        cyc(0, 0, 0, 1, 5'd10);
        cyc(0, 0, 0, 1, 5'd11);
        cyc(0, 0, 0, 1, 5'd13);
        cyc(1, 0, 0, 1, 5'd14);
        repeat (5) cyc(0, 0, 0, 0, 5'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 20) ? 1'b1 : 1'b0,
                ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                5'($urandom_range(31)));
        end
        repeat (5) cyc(0, 0, 0, 0, 5'd0);

        // Everything queued must have been compared
        @(negedge clk);
        #1;
        check("a_drain", 32'(sb_a.size()), 32'd0);
        check("b_drain", 32'(sb_b.size()), 32'd0);
        check("c_drain", 32'(sb_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
